// File: rtl/button_evt_pkg.sv
// Shared types for the button event controller: event codes and the
// per-button press/hold/repeat state encoding.
package button_evt_pkg;

   typedef enum logic [1:0] {
      EVT_PRESS   = 2'd0,
      EVT_RELEASE = 2'd1,
      EVT_LONG    = 2'd2,
      EVT_REPEAT  = 2'd3
   } evt_type_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } btn_state_t;

   // Counter width able to hold the values 0..n-1 (never narrower than one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button: 2-flop synchronizer, tick-sampled debounce counter and the
// press/hold/repeat state machine producing a single-cycle event strobe.
module button_event_fsm
   import button_evt_pkg::*;
#(
   parameter int STABLE_N     = 8,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 20
)(
   input  logic      clk,
   input  logic      reset,
   input  logic      tick,
   input  logic      btn_raw,
   output logic      db_level,
   output logic      evt_strobe,
   output evt_type_t evt_type
);

   localparam int DW       = cnt_width(STABLE_N);
   localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int HW       = cnt_width(HOLD_MAX);

   localparam logic [DW-1:0] DCNT_LAST = DW'(STABLE_N - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS - 1);

   logic          sync_meta;
   logic          sync;
   logic [DW-1:0] dcnt;
   logic [HW-1:0] hold;
   btn_state_t    state;
   logic          differ;
   logic          flip;
   logic          rise;
   logic          fall;

   assign differ = (sync != db_level);
   assign flip   = tick && differ && (dcnt == DCNT_LAST);
   assign rise   = flip && sync;
   assign fall   = flip && !sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         sync      <= sync_meta;
      end
   end

   // A sample that agrees with the debounced level restarts the count, so
   // only STABLE_N consecutive disagreeing ticks can flip the level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt     <= '0;
         db_level <= 1'b0;
      end else if (tick) begin
         if (!differ) begin
            dcnt <= '0;
         end else if (dcnt == DCNT_LAST) begin
            dcnt     <= '0;
            db_level <= ~db_level;
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         hold  <= '0;
      end else if (tick) begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state <= HELD;
                  hold  <= '0;
               end
            end
            HELD: begin
               if (fall) begin
                  state <= IDLE;
               end else if (hold == LONG_LAST) begin
                  state <= REPEAT;
                  hold  <= '0;
               end else begin
                  hold <= hold + HW'(1);
               end
            end
            REPEAT: begin
               if (fall) begin
                  state <= IDLE;
               end else if (hold == REP_LAST) begin
                  hold <= '0;
               end else begin
                  hold <= hold + HW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The strobe is decoded during the tick cycle itself so the pending slot
   // in the parent captures it on the same edge that advances the state.
   always_comb begin
      evt_strobe = 1'b0;
      evt_type   = EVT_PRESS;
      if (tick) begin
         case (state)
            IDLE: begin
               if (rise) begin
                  evt_strobe = 1'b1;
                  evt_type   = EVT_PRESS;
               end
            end
            HELD: begin
               if (fall) begin
                  evt_strobe = 1'b1;
                  evt_type   = EVT_RELEASE;
               end else if (hold == LONG_LAST) begin
                  evt_strobe = 1'b1;
                  evt_type   = EVT_LONG;
               end
            end
            REPEAT: begin
               if (fall) begin
                  evt_strobe = 1'b1;
                  evt_type   = EVT_RELEASE;
               end else if (hold == REP_LAST) begin
                  evt_strobe = 1'b1;
                  evt_type   = EVT_REPEAT;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: shared sample-tick prescaler, one pending slot per
// button and a round-robin arbiter feeding a registered valid/ready stream.
module button_event_ctrl
   import button_evt_pkg::*;
#(
   parameter int NBTN         = 4,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_N     = 8,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 20
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NBTN-1:0]         btn_in,
   output logic [NBTN-1:0]         db_level,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [$clog2(NBTN)-1:0] evt_btn,
   output logic [1:0]              evt_type,
   output logic [NBTN-1:0]         overflow
);

   localparam int BW = $clog2(NBTN);
   localparam int IW = BW + 1;
   localparam int TW = cnt_width(TICK_DIV);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BTN_LAST  = BW'(NBTN - 1);

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [NBTN-1:0] fsm_strobe;
   evt_type_t       fsm_type [NBTN];
   logic [NBTN-1:0] slot_full;
   evt_type_t       slot_type [NBTN];
   logic [NBTN-1:0] drain;
   logic [BW-1:0]   rr_ptr;
   logic [BW-1:0]   winner;
   logic [IW-1:0]   idx;
   logic            found;
   logic            load;

   assign tick = (tick_cnt == TICK_LAST);
   assign load = !evt_valid || evt_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      end
   end

   for (genvar i = 0; i < NBTN; i++) begin : g_btn
      button_event_fsm #(
         .STABLE_N     (STABLE_N),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_fsm (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .btn_raw    (btn_in[i]),
         .db_level   (db_level[i]),
         .evt_strobe (fsm_strobe[i]),
         .evt_type   (fsm_type[i])
      );
   end

   // Scan the slots starting at rr_ptr and wrapping, taking the first full one.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NBTN; k++) begin
         idx = {1'b0, rr_ptr} + IW'(k);
         if (idx >= IW'(NBTN)) begin
            idx = idx - IW'(NBTN);
         end
         if (!found && slot_full[idx[BW-1:0]]) begin
            found  = 1'b1;
            winner = idx[BW-1:0];
         end
      end
   end

   always_comb begin
      drain = '0;
      if (load && found) begin
         drain[winner] = 1'b1;
      end
   end

   // A slot being drained this cycle may accept a new event; only a full slot
   // that stays full drops the new event and records the overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_full <= '0;
         overflow  <= '0;
         for (int i = 0; i < NBTN; i++) begin
            slot_type[i] <= EVT_PRESS;
         end
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (fsm_strobe[i]) begin
               if (slot_full[i] && !drain[i]) begin
                  overflow[i] <= 1'b1;
               end else begin
                  slot_full[i] <= 1'b1;
                  slot_type[i] <= fsm_type[i];
               end
            end else if (drain[i]) begin
               slot_full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_valid <= 1'b0;
         evt_btn   <= '0;
         evt_type  <= EVT_PRESS;
         rr_ptr    <= '0;
      end else if (load) begin
         if (found) begin
            evt_valid <= 1'b1;
            evt_btn   <= winner;
            evt_type  <= slot_type[winner];
            rr_ptr    <= (winner == BTN_LAST) ? '0 : winner + BW'(1);
         end else begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with a fast tick (TICK_DIV=4); events
// are logged with the clock-edge count since reset release and checked per test.
module tb_button_event_ctrl;

   localparam int NBTN = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  btn_in = 4'b0000;
   logic [3:0]  db_level;
   logic        evt_valid;
   logic        evt_ready = 1'b1;
   logic [1:0]  evt_btn;
   logic [1:0]  evt_type;
   logic [3:0]  overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int ecnt     = 0;
   int qbase    = 0;
   int evq[$];

   always #5 clk = ~clk;

   button_event_ctrl #(
      .NBTN         (NBTN),
      .TICK_DIV     (4),
      .STABLE_N     (3),
      .LONG_TICKS   (5),
      .REPEAT_TICKS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_in),
      .db_level  (db_level),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_btn   (evt_btn),
      .evt_type  (evt_type),
      .overflow  (overflow)
   );

   function automatic int enc(input int stamp, input int b, input int t);
      return stamp * 16 + b * 4 + t;
   endfunction

   // Edge counter: 0 on the last edge seen in reset, n on the n-th edge after.
   always @(posedge clk) begin
      if (reset) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   // Log every accepted event, stamped with the edge after which it became visible.
   always @(negedge clk) begin
      if (!reset && evt_valid && evt_ready)
         evq.push_back(enc(ecnt, int'(evt_btn), int'(evt_type)));
   end

   task automatic wait_edge(input int target);
      while (ecnt < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      qbase = evq.size();
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      btn_in    = 4'b0000;
      evt_ready = 1'b1;
      release_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (db_level !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_db got=%b want=0000", db_level); end
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got=%b want=0", evt_valid); end
      n_checks++; if (evt_btn !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_btn got=%0d want=0", evt_btn); end
      n_checks++; if (evt_type !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_type got=%0d want=0", evt_type); end
      n_checks++; if (overflow !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ovf got=%b want=0000", overflow); end
   endtask

   task automatic test_glitch();
      apply_reset();
      wait_edge(4);  btn_in = 4'b0100;
      wait_edge(8);  btn_in = 4'b0000;
      wait_edge(30);
      n_checks++; if (db_level !== 4'b0000) begin n_fail++; $display("[TB] FAIL glitch_db got=%b want=0000", db_level); end
      n_checks++; if (evq.size() - qbase !== 0) begin n_fail++; $display("[TB] FAIL glitch_events got=%0d want=0", evq.size() - qbase); end
   endtask

   task automatic test_press();
      int exp_ev[$];
      apply_reset();
      wait_edge(4);  btn_in = 4'b0010;
      wait_edge(15);
      n_checks++; if (db_level !== 4'b0000) begin n_fail++; $display("[TB] FAIL press_db_early got=%b want=0000", db_level); end
      wait_edge(16);
      n_checks++; if (db_level !== 4'b0010) begin n_fail++; $display("[TB] FAIL press_db got=%b want=0010", db_level); end
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL press_valid_early got=%b want=0", evt_valid); end
      wait_edge(17);
      n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL press_valid got=%b want=1", evt_valid); end
      n_checks++; if (evt_btn !== 2'd1) begin n_fail++; $display("[TB] FAIL press_btn got=%0d want=1", evt_btn); end
      n_checks++; if (evt_type !== 2'd0) begin n_fail++; $display("[TB] FAIL press_type got=%0d want=0", evt_type); end
      wait_edge(18);
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL press_valid_drop got=%b want=0", evt_valid); end
      exp_ev = '{enc(17, 1, 0)};
      n_checks++; if (evq.size() - qbase !== exp_ev.size()) begin n_fail++; $display("[TB] FAIL press_count got=%0d want=%0d", evq.size() - qbase, exp_ev.size()); end
      for (int k = 0; k < exp_ev.size(); k++) begin
         int got = (qbase + k < evq.size()) ? evq[qbase + k] : -1;
         n_checks++;
         if (got !== exp_ev[k]) begin n_fail++; $display("[TB] FAIL press_ev%0d got stamp=%0d btn=%0d type=%0d want stamp=%0d btn=%0d type=%0d", k, got / 16, (got % 16) / 4, got % 4, exp_ev[k] / 16, (exp_ev[k] % 16) / 4, exp_ev[k] % 4); end
      end
   endtask

   task automatic test_long_repeat();
      int exp_ev[$];
      apply_reset();
      wait_edge(4);  btn_in = 4'b0001;
      wait_edge(37);
      n_checks++; if (evt_valid !== 1'b1 || evt_type !== 2'd2 || evt_btn !== 2'd0) begin n_fail++; $display("[TB] FAIL long_out got valid=%b btn=%0d type=%0d want valid=1 btn=0 type=2", evt_valid, evt_btn, evt_type); end
      wait_edge(64); btn_in = 4'b0000;
      wait_edge(80);
      n_checks++; if (db_level !== 4'b0000) begin n_fail++; $display("[TB] FAIL long_db_release got=%b want=0000", db_level); end
      exp_ev = '{enc(17, 0, 0), enc(37, 0, 2), enc(45, 0, 3), enc(53, 0, 3), enc(61, 0, 3), enc(69, 0, 3), enc(77, 0, 1)};
      n_checks++; if (evq.size() - qbase !== exp_ev.size()) begin n_fail++; $display("[TB] FAIL long_count got=%0d want=%0d", evq.size() - qbase, exp_ev.size()); end
      for (int k = 0; k < exp_ev.size(); k++) begin
         int got = (qbase + k < evq.size()) ? evq[qbase + k] : -1;
         n_checks++;
         if (got !== exp_ev[k]) begin n_fail++; $display("[TB] FAIL long_ev%0d got stamp=%0d btn=%0d type=%0d want stamp=%0d btn=%0d type=%0d", k, got / 16, (got % 16) / 4, got % 4, exp_ev[k] / 16, (exp_ev[k] % 16) / 4, exp_ev[k] % 4); end
      end
   endtask

   task automatic test_back_to_back();
      int exp_ev[$];
      apply_reset();
      wait_edge(4);  btn_in = 4'b1001;
      wait_edge(20); btn_in = 4'b0000;
      wait_edge(40);
      exp_ev = '{enc(17, 0, 0), enc(18, 3, 0), enc(33, 0, 1), enc(34, 3, 1)};
      n_checks++; if (evq.size() - qbase !== exp_ev.size()) begin n_fail++; $display("[TB] FAIL b2b_count got=%0d want=%0d", evq.size() - qbase, exp_ev.size()); end
      for (int k = 0; k < exp_ev.size(); k++) begin
         int got = (qbase + k < evq.size()) ? evq[qbase + k] : -1;
         n_checks++;
         if (got !== exp_ev[k]) begin n_fail++; $display("[TB] FAIL b2b_ev%0d got stamp=%0d btn=%0d type=%0d want stamp=%0d btn=%0d type=%0d", k, got / 16, (got % 16) / 4, got % 4, exp_ev[k] / 16, (exp_ev[k] % 16) / 4, exp_ev[k] % 4); end
      end
   endtask

   task automatic test_rr_ptr();
      int exp_ev[$];
      apply_reset();
      wait_edge(4);  btn_in = 4'b0001;
      wait_edge(24); btn_in = 4'b1001;
      wait_edge(40);
      exp_ev = '{enc(17, 0, 0), enc(37, 3, 0), enc(38, 0, 2)};
      n_checks++; if (evq.size() - qbase !== exp_ev.size()) begin n_fail++; $display("[TB] FAIL rr_count got=%0d want=%0d", evq.size() - qbase, exp_ev.size()); end
      for (int k = 0; k < exp_ev.size(); k++) begin
         int got = (qbase + k < evq.size()) ? evq[qbase + k] : -1;
         n_checks++;
         if (got !== exp_ev[k]) begin n_fail++; $display("[TB] FAIL rr_ev%0d got stamp=%0d btn=%0d type=%0d want stamp=%0d btn=%0d type=%0d", k, got / 16, (got % 16) / 4, got % 4, exp_ev[k] / 16, (exp_ev[k] % 16) / 4, exp_ev[k] % 4); end
      end
   endtask

   task automatic test_overflow();
      int exp_ev[$];
      apply_reset();
      evt_ready = 1'b0;
      wait_edge(4);  btn_in = 4'b0010;
      wait_edge(20);
      n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 2'd1 || evt_type !== 2'd0) begin n_fail++; $display("[TB] FAIL ovf_hold1 got valid=%b btn=%0d type=%0d want valid=1 btn=1 type=0", evt_valid, evt_btn, evt_type); end
      wait_edge(28); btn_in = 4'b0000;
      wait_edge(39);
      n_checks++; if (overflow !== 4'b0000) begin n_fail++; $display("[TB] FAIL ovf_early got=%b want=0000", overflow); end
      n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 2'd1 || evt_type !== 2'd0) begin n_fail++; $display("[TB] FAIL ovf_hold2 got valid=%b btn=%0d type=%0d want valid=1 btn=1 type=0", evt_valid, evt_btn, evt_type); end
      wait_edge(40);
      n_checks++; if (overflow !== 4'b0010) begin n_fail++; $display("[TB] FAIL ovf_set got=%b want=0010", overflow); end
      wait_edge(45);
      n_checks++; if (evt_valid !== 1'b1 || evt_btn !== 2'd1 || evt_type !== 2'd0) begin n_fail++; $display("[TB] FAIL ovf_hold3 got valid=%b btn=%0d type=%0d want valid=1 btn=1 type=0", evt_valid, evt_btn, evt_type); end
      evt_ready = 1'b1;
      wait_edge(50);
      n_checks++; if (overflow !== 4'b0010) begin n_fail++; $display("[TB] FAIL ovf_sticky got=%b want=0010", overflow); end
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_drained got=%b want=0", evt_valid); end
      exp_ev = '{enc(45, 1, 0), enc(46, 1, 2)};
      n_checks++; if (evq.size() - qbase !== exp_ev.size()) begin n_fail++; $display("[TB] FAIL ovf_count got=%0d want=%0d", evq.size() - qbase, exp_ev.size()); end
      for (int k = 0; k < exp_ev.size(); k++) begin
         int got = (qbase + k < evq.size()) ? evq[qbase + k] : -1;
         n_checks++;
         if (got !== exp_ev[k]) begin n_fail++; $display("[TB] FAIL ovf_ev%0d got stamp=%0d btn=%0d type=%0d want stamp=%0d btn=%0d type=%0d", k, got / 16, (got % 16) / 4, got % 4, exp_ev[k] / 16, (exp_ev[k] % 16) / 4, exp_ev[k] % 4); end
      end
   endtask

   task automatic test_reset_mid();
      int exp_ev[$];
      apply_reset();
      evt_ready = 1'b0;
      wait_edge(4);  btn_in = 4'b0100;
      wait_edge(46);
      n_checks++; if (evt_valid !== 1'b1 || db_level !== 4'b0100 || overflow !== 4'b0100) begin n_fail++; $display("[TB] FAIL mid_pre got valid=%b db=%b ovf=%b want valid=1 db=0100 ovf=0100", evt_valid, db_level, overflow); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid got=%b want=0", evt_valid); end
      n_checks++; if (db_level !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_db got=%b want=0000", db_level); end
      n_checks++; if (overflow !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_ovf got=%b want=0000", overflow); end
      evt_ready = 1'b1;
      release_reset();
      wait_edge(11);
      n_checks++; if (db_level !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_db_early got=%b want=0000", db_level); end
      wait_edge(12);
      n_checks++; if (db_level !== 4'b0100) begin n_fail++; $display("[TB] FAIL mid_db_flip got=%b want=0100", db_level); end
      wait_edge(14);
      exp_ev = '{enc(13, 2, 0)};
      n_checks++; if (evq.size() - qbase !== exp_ev.size()) begin n_fail++; $display("[TB] FAIL mid_count got=%0d want=%0d", evq.size() - qbase, exp_ev.size()); end
      for (int k = 0; k < exp_ev.size(); k++) begin
         int got = (qbase + k < evq.size()) ? evq[qbase + k] : -1;
         n_checks++;
         if (got !== exp_ev[k]) begin n_fail++; $display("[TB] FAIL mid_ev%0d got stamp=%0d btn=%0d type=%0d want stamp=%0d btn=%0d type=%0d", k, got / 16, (got % 16) / 4, got % 4, exp_ev[k] / 16, (exp_ev[k] % 16) / 4, exp_ev[k] % 4); end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_press();
      test_long_repeat();
      test_back_to_back();
      test_rr_ptr();
      test_overflow();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "[TB] watchdog");
   end

endmodule
